clint_tr: RTL and testbench

Core-local interrupt/exception sequencer. It detects synchronous traps (ecall, ebreak), mret, and asynchronous interrupts at the instruction in execute. It stalls the pipeline through `control_tr` via `hold_flag_clint_i`, then writes mepc/mcause/mstatus to the CSR file one per cycle. Finally it issues a one-cycle redirect (`int_assert_o`/`int_addr_o`) to ex, which forwards it as a jump.

---
 rtl/clint_tr.sv | 164 ++++++++++++++++
 tb/tb_clint_tr.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_tr.sv
// clint_tr -- core-local interrupt/exception sequencer.
//
// Watches the instruction in execute for ecall, ebreak and mret. It also
// watches for a pending, enabled asynchronous interrupt. On a trigger it
// stalls the pipeline and writes the trap CSRs one per cycle, then issues a
// single-cycle redirect to ex.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   int_flag_i[7:0]       pending interrupt lines (level, any bit = request)
//   inst_i, inst_addr_i   instruction in execute and its PC
//   jump_flag_i/addr_i    ex redirect in progress this cycle and its target
//   div_started_i         multi-cycle divide in flight (defers interrupts)
//   csr_mtvec_i, csr_mepc_i, csr_mstatus_i   current CSR values
//   global_int_en_i       mstatus.MIE as seen by the CSR file
//   hold_flag_o           stall request to control_tr
//   we_o, waddr_o, data_o CSR write port
//   int_assert_o/addr_o   one-cycle redirect pulse and target
module clint_tr #(
  parameter logic [31:0] ECALL_CAUSE  = 32'd11,
  parameter logic [31:0] EBREAK_CAUSE = 32'd3,
  parameter logic [31:0] ASYNC_CAUSE  = 32'h8000_0007
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  int_flag_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        div_started_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  input  logic        global_int_en_i,
  output logic        hold_flag_o,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] data_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;
  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    ASSERT,
    MRET_MSTATUS,
    MRET_ASSERT
  } state_t;

  state_t      state;
  logic [31:0] mepc_q;
  logic [31:0] cause_q;

  logic is_ecall;
  logic is_ebreak;
  logic is_mret;
  logic is_async;
  logic trigger;

  // Detection only matters in IDLE; an interrupt held off by a divide simply
  // stays pending on the level input until the divide finishes.
  always_comb begin
    is_ecall  = (inst_i == INST_ECALL);
    is_ebreak = (inst_i == INST_EBREAK);
    is_mret   = (inst_i == INST_MRET);
    is_async  = (|int_flag_i) && global_int_en_i && !div_started_i;
    trigger   = (state == IDLE) && (is_ecall || is_ebreak || is_mret || is_async);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      mepc_q  <= '0;
      cause_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_ecall) begin
            mepc_q  <= inst_addr_i;
            cause_q <= ECALL_CAUSE;
            state   <= W_MEPC;
          end else if (is_ebreak) begin
            mepc_q  <= inst_addr_i;
            cause_q <= EBREAK_CAUSE;
            state   <= W_MEPC;
          end else if (is_mret) begin
            state   <= MRET_MSTATUS;
          end else if (is_async) begin
            // Resume at the redirect target if ex is jumping this cycle.
            mepc_q  <= jump_flag_i ? jump_addr_i : inst_addr_i;
            cause_q <= ASYNC_CAUSE;
            state   <= W_MEPC;
          end
        end
        W_MEPC:       state <= W_MCAUSE;
        W_MCAUSE:     state <= W_MSTATUS;
        W_MSTATUS:    state <= ASSERT;
        ASSERT:       state <= IDLE;
        MRET_MSTATUS: state <= MRET_ASSERT;
        MRET_ASSERT:  state <= IDLE;
        default:      state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state so the stall covers the detection cycle and
  // mstatus writes use the CSR value current in the write cycle.
  always_comb begin
    hold_flag_o  = (state != IDLE) || trigger;
    we_o         = 1'b0;
    waddr_o      = '0;
    data_o       = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    case (state)
      W_MEPC: begin
        we_o    = 1'b1;
        waddr_o = CSR_MEPC;
        data_o  = mepc_q;
      end
      W_MCAUSE: begin
        we_o    = 1'b1;
        waddr_o = CSR_MCAUSE;
        data_o  = cause_q;
      end
      W_MSTATUS: begin
        we_o      = 1'b1;
        waddr_o   = CSR_MSTATUS;
        data_o    = csr_mstatus_i;
        data_o[7] = csr_mstatus_i[3];
        data_o[3] = 1'b0;
      end
      ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = csr_mtvec_i;
      end
      MRET_MSTATUS: begin
        we_o      = 1'b1;
        waddr_o   = CSR_MSTATUS;
        data_o    = csr_mstatus_i;
        data_o[3] = csr_mstatus_i[7];
        data_o[7] = 1'b1;
      end
      MRET_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = csr_mepc_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clint_tr.sv
// Directed testbench for clint_tr. Inputs change 1 ns after the rising edge;
// outputs are sampled on the falling edge. The observed bus is
// {hold, we, int_assert, waddr, data, int_addr}.
module tb_clint_tr;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  int_flag;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        div_started;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mstatus;
  logic        mie;
  logic        hold_flag;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        int_assert;
  logic [31:0] int_addr;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  always #5 clk = ~clk;

  clint_tr dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .int_flag_i      (int_flag),
    .inst_i          (inst),
    .inst_addr_i     (inst_addr),
    .jump_flag_i     (jump_flag),
    .jump_addr_i     (jump_addr),
    .div_started_i   (div_started),
    .csr_mtvec_i     (mtvec),
    .csr_mepc_i      (mepc),
    .csr_mstatus_i   (mstatus),
    .global_int_en_i (mie),
    .hold_flag_o     (hold_flag),
    .we_o            (we),
    .waddr_o         (waddr),
    .data_o          (wdata),
    .int_assert_o    (int_assert),
    .int_addr_o      (int_addr)
  );

  logic [98:0] obs;
  assign obs = {hold_flag, we, int_assert, waddr, wdata, int_addr};

  function automatic logic [98:0] ex(input logic h, input logic w, input logic a,
                                     input logic [31:0] wa, input logic [31:0] d,
                                     input logic [31:0] ia);
    return {h, w, a, wa, d, ia};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++;
    if (obs !== ex(0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", obs, ex(0, 0, 0, 0, 0, 0));
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== ex(0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_release got=%h exp=%h", obs, ex(0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_ecall();
    logic [98:0] exp_t [0:5];
    exp_t[0] = ex(1, 0, 0, 0, 0, 0);
    exp_t[1] = ex(1, 1, 0, 32'h341, 32'h100, 0);
    exp_t[2] = ex(1, 1, 0, 32'h342, 32'd11, 0);
    exp_t[3] = ex(1, 1, 0, 32'h300, 32'h80, 0);
    exp_t[4] = ex(1, 0, 1, 0, 0, 32'h200);
    exp_t[5] = ex(0, 0, 0, 0, 0, 0);
    step();
    inst = ECALL; inst_addr = 32'h100; mtvec = 32'h200; mstatus = 32'h8;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_t[i]) begin
        errors++; $display("FAIL ecall_T%0d got=%h exp=%h", i, obs, exp_t[i]);
      end
      step();
      inst = NOP;
    end
  endtask

  task automatic test_mret();
    logic [98:0] exp_t [0:3];
    exp_t[0] = ex(1, 0, 0, 0, 0, 0);
    exp_t[1] = ex(1, 1, 0, 32'h300, 32'h88, 0);
    exp_t[2] = ex(1, 0, 1, 0, 0, 32'h104);
    exp_t[3] = ex(0, 0, 0, 0, 0, 0);
    inst = MRET; mstatus = 32'h80; mepc = 32'h104;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_t[i]) begin
        errors++; $display("FAIL mret_T%0d got=%h exp=%h", i, obs, exp_t[i]);
      end
      step();
      inst = NOP;
    end
  endtask

  task automatic test_ebreak();
    logic [98:0] exp_t [0:5];
    exp_t[0] = ex(1, 0, 0, 0, 0, 0);
    exp_t[1] = ex(1, 1, 0, 32'h341, 32'h40, 0);
    exp_t[2] = ex(1, 1, 0, 32'h342, 32'd3, 0);
    exp_t[3] = ex(1, 1, 0, 32'h300, 32'h1880, 0);
    exp_t[4] = ex(1, 0, 1, 0, 0, 32'h200);
    exp_t[5] = ex(0, 0, 0, 0, 0, 0);
    inst = EBREAK; inst_addr = 32'h40; mstatus = 32'h1808;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_t[i]) begin
        errors++; $display("FAIL ebreak_T%0d got=%h exp=%h", i, obs, exp_t[i]);
      end
      step();
      inst = NOP;
    end
  endtask

  task automatic test_async_jump();
    logic [98:0] exp_t [0:5];
    exp_t[0] = ex(1, 0, 0, 0, 0, 0);
    exp_t[1] = ex(1, 1, 0, 32'h341, 32'h300, 0);
    exp_t[2] = ex(1, 1, 0, 32'h342, 32'h8000_0007, 0);
    exp_t[3] = ex(1, 1, 0, 32'h300, 32'h80, 0);
    exp_t[4] = ex(1, 0, 1, 0, 0, 32'h200);
    exp_t[5] = ex(0, 0, 0, 0, 0, 0);
    inst = NOP; inst_addr = 32'h500; mstatus = 32'h8;
    int_flag = 8'h01; mie = 1'b1; jump_flag = 1'b1; jump_addr = 32'h300;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_t[i]) begin
        errors++; $display("FAIL async_jump_T%0d got=%h exp=%h", i, obs, exp_t[i]);
      end
      step();
      int_flag = 8'h00; jump_flag = 1'b0; jump_addr = 32'h0;
    end
  endtask

  task automatic test_div_defer();
    logic [98:0] exp_t [0:5];
    exp_t[0] = ex(1, 0, 0, 0, 0, 0);
    exp_t[1] = ex(1, 1, 0, 32'h341, 32'h600, 0);
    exp_t[2] = ex(1, 1, 0, 32'h342, 32'h8000_0007, 0);
    exp_t[3] = ex(1, 1, 0, 32'h300, 32'h80, 0);
    exp_t[4] = ex(1, 0, 1, 0, 0, 32'h200);
    exp_t[5] = ex(0, 0, 0, 0, 0, 0);
    inst_addr = 32'h600; int_flag = 8'h01; mie = 1'b1; div_started = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== ex(0, 0, 0, 0, 0, 0)) begin
        errors++; $display("FAIL div_defer_c%0d got=%h exp=%h", i, obs, ex(0, 0, 0, 0, 0, 0));
      end
      step();
    end
    div_started = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_t[i]) begin
        errors++; $display("FAIL div_release_T%0d got=%h exp=%h", i, obs, exp_t[i]);
      end
      step();
      int_flag = 8'h00;
    end
  endtask

  task automatic test_mask();
    int_flag = 8'hFF; mie = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({hold_flag, we, int_assert} !== 3'b000) begin
        errors++; $display("FAIL mask_c%0d got=%b exp=000", i, {hold_flag, we, int_assert});
      end
      step();
    end
    int_flag = 8'h00;
  endtask

  task automatic test_priority();
    logic [98:0] exp_t [0:5];
    exp_t[0] = ex(1, 0, 0, 0, 0, 0);
    exp_t[1] = ex(1, 1, 0, 32'h341, 32'h120, 0);
    exp_t[2] = ex(1, 1, 0, 32'h342, 32'd11, 0);
    exp_t[3] = ex(1, 1, 0, 32'h300, 32'h80, 0);
    exp_t[4] = ex(1, 0, 1, 0, 0, 32'h200);
    exp_t[5] = ex(0, 0, 0, 0, 0, 0);
    inst = ECALL; inst_addr = 32'h120; mstatus = 32'h8;
    int_flag = 8'h80; mie = 1'b1; jump_flag = 1'b1; jump_addr = 32'h700;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_t[i]) begin
        errors++; $display("FAIL priority_T%0d got=%h exp=%h", i, obs, exp_t[i]);
      end
      step();
      inst = NOP; jump_flag = 1'b0;
      // Interrupt stays asserted through the sequence but MIE now reads 0.
      mie = 1'b0;
    end
    int_flag = 8'h00;
  endtask

  task automatic test_reset_mid();
    logic [98:0] exp_t [0:5];
    exp_t[0] = ex(1, 0, 0, 0, 0, 0);
    exp_t[1] = ex(1, 1, 0, 32'h341, 32'h180, 0);
    exp_t[2] = ex(1, 1, 0, 32'h342, 32'd11, 0);
    exp_t[3] = ex(1, 1, 0, 32'h300, 32'h80, 0);
    exp_t[4] = ex(1, 0, 1, 0, 0, 32'h200);
    exp_t[5] = ex(0, 0, 0, 0, 0, 0);
    inst = ECALL; inst_addr = 32'h180; mstatus = 32'h8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_t[i]) begin
        errors++; $display("FAIL rstmid_T%0d got=%h exp=%h", i, obs, exp_t[i]);
      end
      if (i == 2) rst = 1'b1;
      step();
      inst = NOP;
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== ex(0, 0, 0, 0, 0, 0)) begin
        errors++; $display("FAIL rstmid_idle_c%0d got=%h exp=%h", i, obs, ex(0, 0, 0, 0, 0, 0));
      end
      step();
    end
    inst = ECALL;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_t[i]) begin
        errors++; $display("FAIL rstmid_fresh_T%0d got=%h exp=%h", i, obs, exp_t[i]);
      end
      step();
      inst = NOP;
    end
  endtask

  initial begin
    rst = 1'b1; int_flag = '0; inst = NOP; inst_addr = '0;
    jump_flag = 1'b0; jump_addr = '0; div_started = 1'b0;
    mtvec = 32'h200; mepc = '0; mstatus = '0; mie = 1'b0;
    test_reset();
    test_ecall();
    test_mret();
    test_ebreak();
    test_async_jump();
    test_div_defer();
    test_mask();
    test_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
